// File: rtl/sha256_pkg.sv
// Shared constants and types for the 80-byte header SHA-256 sequencer.
// SHA256_DOUBLE_HASH_EN adds the LOAD2/WAIT2 states used for a second hash pass.
package sha256_pkg;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] PAD_ONE = 32'h80000000;
  localparam logic [31:0] LEN_640 = 32'h00000280;
  localparam logic [31:0] LEN_256 = 32'h00000100;

  localparam int CORE_TIMEOUT_DEFAULT = 255;

  typedef enum logic [3:0] {
    IDLE,
    LOAD0,
    WAIT0,
    LOAD1,
    WAIT1,
`ifdef SHA256_DOUBLE_HASH_EN
    LOAD2,
    WAIT2,
`endif
    DONE,
    ERR
  } seq_state_t;

  // Which 512-bit message block the formatter presents to the core.
  typedef enum logic [1:0] {
    BLK_HDR_HI,
    BLK_HDR_LO,
    BLK_DIGEST
  } blk_sel_t;

endpackage

// File: rtl/sha256_80b_pad.sv
// Combinational formatter: builds the 512-bit core message block from the
// captured header or a previous digest, including SHA-256 padding and length.
module sha256_80b_pad
  import sha256_pkg::*;
(
  input  logic [639:0] header,
  input  logic [255:0] midstate,
  input  blk_sel_t     blk,
  output logic [511:0] data
);

  always_comb begin
    // NOTE: default assignment first so no path leaves data unassigned (no latch).
    data = '0;
    unique case (blk)
      BLK_HDR_HI: data = header[639:128];
      BLK_HDR_LO: data = {header[127:0], PAD_ONE, 320'h0, LEN_640};
      BLK_DIGEST: data = {midstate, PAD_ONE, 192'h0, LEN_256};
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/sha256_80b_sequencer.sv
// Drives an external SHA-256 compression core over the two padded blocks of an
// 80-byte header. Define SHA256_DOUBLE_HASH_EN to hash the result a second time.
module sha256_80b_sequencer
  import sha256_pkg::*;
#(
  parameter logic [255:0] IV           = SHA256_IV,
  parameter int           CORE_TIMEOUT = CORE_TIMEOUT_DEFAULT
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [639:0] header,
  output logic         busy,
  output logic [255:0] digest,
  output logic         done,
  output logic         error,
  output logic         core_enable,
  output logic [511:0] core_data,
  output logic [255:0] core_current_hash,
  input  logic [255:0] core_hash,
  input  logic         core_hash_done
);

  localparam int CW = $clog2(CORE_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(CORE_TIMEOUT - 1);

  seq_state_t     state;
  blk_sel_t       blk;
  logic [639:0]   header_q;
  logic [255:0]   midstate;
  logic [CW-1:0]  cnt;
  logic           timeout_hit;

  // Block data is a pure function of registers, so it is stable for the
  // whole LOAD..WAIT window without a separate output register.
  sha256_80b_pad u_pad (
    .header   (header_q),
    .midstate (midstate),
    .blk      (blk),
    .data     (core_data)
  );

  assign timeout_hit = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state             <= IDLE;
      blk               <= BLK_HDR_HI;
      header_q          <= '0;
      midstate          <= '0;
      cnt               <= '0;
      busy              <= 1'b0;
      digest            <= '0;
      done              <= 1'b0;
      error             <= 1'b0;
      core_enable       <= 1'b0;
      core_current_hash <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
      core_enable <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            header_q          <= header;
            blk               <= BLK_HDR_HI;
            core_current_hash <= IV;
            core_enable       <= 1'b1;
            busy              <= 1'b1;
            state             <= LOAD0;
          end
        end
        LOAD0: begin
          cnt   <= '0;
          state <= WAIT0;
        end
        WAIT0: begin
          if (core_hash_done) begin
            midstate          <= core_hash;
            core_current_hash <= core_hash;
            blk               <= BLK_HDR_LO;
            core_enable       <= 1'b1;
            state             <= LOAD1;
          end else if (timeout_hit) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD1: begin
          cnt   <= '0;
          state <= WAIT1;
        end
        WAIT1: begin
          if (core_hash_done) begin
`ifdef SHA256_DOUBLE_HASH_EN
            midstate          <= core_hash;
            core_current_hash <= IV;
            blk               <= BLK_DIGEST;
            core_enable       <= 1'b1;
            state             <= LOAD2;
`else
            digest <= core_hash;
            done   <= 1'b1;
            state  <= DONE;
`endif
          end else if (timeout_hit) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef SHA256_DOUBLE_HASH_EN
        LOAD2: begin
          cnt   <= '0;
          state <= WAIT2;
        end
        WAIT2: begin
          if (core_hash_done) begin
            digest <= core_hash;
            done   <= 1'b1;
            state  <= DONE;
          end else if (timeout_hit) begin
            error <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        DONE, ERR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_80b_sequencer.sv
// Directed bench for sha256_80b_sequencer with a behavioural SHA-256 core model.
// Honours SHA256_DOUBLE_HASH_EN to expect the second hash pass.
module tb_sha256_80b_sequencer;
  import sha256_pkg::*;

`ifdef SHA256_DOUBLE_HASH_EN
  localparam int NBLK = 3;
`else
  localparam int NBLK = 2;
`endif

  localparam logic [639:0] GENESIS = 640'h01000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_00000000_3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a_29ab5f49_ffff001d_1dac2b7c;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [639:0] header;
  logic         busy;
  logic [255:0] digest;
  logic         done;
  logic         error;
  logic         core_enable;
  logic [511:0] core_data;
  logic [255:0] core_current_hash;
  logic [255:0] core_hash;
  logic         core_hash_done;

  sha256_80b_sequencer dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .start             (start),
    .header            (header),
    .busy              (busy),
    .digest            (digest),
    .done              (done),
    .error             (error),
    .core_enable       (core_enable),
    .core_data         (core_data),
    .core_current_hash (core_current_hash),
    .core_hash         (core_hash),
    .core_hash_done    (core_hash_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observation counters, all written only by the core model process.
  int cyc = 0, en_cnt = 0, en_cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
  int spur_seen = 0;
  int spur_req  = 0;
  int lat       = 20;
  bit respond   = 1'b1;
  logic [511:0] data_log [$];
  logic [255:0] hash_log [$];

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96]  + e, hin[95:64]    + f, hin[63:32]    + g, hin[31:0]     + h};
  endfunction

  function automatic logic [255:0] exp_digest(input logic [639:0] hdr);
    logic [255:0] m;
    logic [255:0] d;
    m = compress(SHA256_IV, hdr[639:128]);
    d = compress(m, {hdr[127:0], 32'h80000000, 320'h0, 32'h00000280});
`ifdef SHA256_DOUBLE_HASH_EN
    d = compress(SHA256_IV, {d, 32'h80000000, 192'h0, 32'h00000100});
`endif
    return d;
  endfunction

  // Behavioural core: samples its inputs one cycle after core_enable and
  // answers lat cycles later; everything happens on the falling edge.
  initial begin
    int pend;
    bit sample_next;
    logic [255:0] res;
    pend = 0; sample_next = 1'b0; res = '0;
    core_hash = '0; core_hash_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      core_hash_done = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (error === 1'b1) begin err_cnt++; err_cyc = cyc; end
      if (n_rst !== 1'b1) begin
        pend = 0; sample_next = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin core_hash = res; core_hash_done = 1'b1; end
        end
        if (sample_next) begin
          data_log.push_back(core_data);
          hash_log.push_back(core_current_hash);
          res = compress(core_current_hash, core_data);
          sample_next = 1'b0;
          if (respond) pend = lat;
        end
        if (core_enable === 1'b1) begin en_cnt++; en_cyc = cyc; sample_next = 1'b1; end
        if (spur_seen != spur_req) begin
          spur_seen++;
          core_hash = 256'hdeadbeef_0badf00d_deadbeef_0badf00d_deadbeef_0badf00d_deadbeef_0badf00d;
          core_hash_done = 1'b1;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_pulse(input logic [639:0] hdr);
    header = hdr;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (done === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_en(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (en_cnt >= target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  logic [639:0] hdr_a = {20{32'ha5c30f1e}};
  logic [639:0] hdr_b = {20{32'h12345678}};

  initial begin
    bit ok;
    int base, d0, e0, en0;

    n_rst = 1'b0; start = 1'b0; header = '0;
    tick(); tick();
    check("rst_busy",   640'(busy),              640'(1'b0));
    check("rst_done",   640'(done),              640'(1'b0));
    check("rst_error",  640'(error),             640'(1'b0));
    check("rst_enable", 640'(core_enable),       640'(1'b0));
    check("rst_data",   640'(core_data),         640'(0));
    check("rst_hash",   640'(core_current_hash), 640'(0));
    check("rst_digest", 640'(digest),            640'(0));

    n_rst = 1'b1;
    repeat (20) tick();
    check("idle_no_enable", 640'(en_cnt), 640'(0));
    check("idle_busy",      640'(busy),   640'(1'b0));

    // 80 zero bytes
    base = data_log.size(); d0 = done_cnt; e0 = err_cnt;
    start_pulse('0);
    check("zero_busy_after_start", 640'(busy), 640'(1'b1));
    wait_done(ok);
    check("zero_done_seen", 640'(ok), 640'(1'b1));
    tick();
    check("zero_busy_after_done", 640'(busy), 640'(1'b0));
    check("zero_enable_count", 640'(en_cnt - base), 640'(NBLK));
    check("zero_blk0_hash",  640'(hash_log[base]),     640'(SHA256_IV));
    check("zero_blk1_data",  640'(data_log[base + 1]), 640'({128'h0, 32'h80000000, 320'h0, 32'h00000280}));
    check("zero_blk1_hash",  640'(hash_log[base + 1]), 640'(compress(SHA256_IV, 512'h0)));
    check("zero_digest",     640'(digest),             640'(exp_digest('0)));
    check("zero_done_count", 640'(done_cnt - d0),      640'(1));
    check("zero_no_error",   640'(err_cnt - e0),       640'(0));

    // stray core_hash_done in IDLE
    en0 = en_cnt; d0 = done_cnt;
    spur_req++;
    repeat (5) tick();
    check("spur_no_enable", 640'(en_cnt - en0),   640'(0));
    check("spur_no_done",   640'(done_cnt - d0),  640'(0));
    check("spur_digest",    640'(digest),         640'(exp_digest('0)));
    check("spur_busy",      640'(busy),           640'(1'b0));

    // genesis header
    start_pulse(GENESIS);
    wait_done(ok);
    check("gen_done_seen", 640'(ok), 640'(1'b1));
    check("gen_digest", 640'(digest), 640'(exp_digest(GENESIS)));
`ifdef SHA256_DOUBLE_HASH_EN
    check("gen_known_digest", 640'(digest),
          640'(256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000));
`endif
    tick();

    // start retriggered with another header while busy
    lat = 40;
    base = data_log.size(); en0 = en_cnt;
    start_pulse(hdr_a);
    wait_en(en0 + 1, ok);
    check("retrig_first_enable", 640'(ok), 640'(1'b1));
    repeat (5) begin
      header = hdr_b; start = 1'b1; tick();
      start = 1'b0; tick();
    end
    wait_done(ok);
    check("retrig_done_seen", 640'(ok), 640'(1'b1));
    check("retrig_blk0_data", 640'(data_log[base]), 640'(hdr_a[639:128]));
    check("retrig_enable_count", 640'(en_cnt - en0), 640'(NBLK));
    check("retrig_digest", 640'(digest), 640'(exp_digest(hdr_a)));
    tick();

    // core never answers
    respond = 1'b0; d0 = done_cnt; e0 = err_cnt;
    start_pulse(hdr_b);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (error === 1'b1) begin ok = 1'b1; break; end
    end
    check("timeout_error_seen", 640'(ok), 640'(1'b1));
    check("timeout_latency", 640'(err_cyc - en_cyc), 640'(CORE_TIMEOUT_DEFAULT + 1));
    tick();
    check("timeout_error_count", 640'(err_cnt - e0),  640'(1));
    check("timeout_no_done",     640'(done_cnt - d0), 640'(0));
    check("timeout_busy",        640'(busy),          640'(1'b0));
    check("timeout_digest_kept", 640'(digest),        640'(exp_digest(hdr_a)));
    respond = 1'b1;

    // reset asserted while waiting on the second block
    lat = 40; en0 = en_cnt; d0 = done_cnt; e0 = err_cnt;
    start_pulse(hdr_b);
    wait_en(en0 + 2, ok);
    check("rst_mid_reached_blk1", 640'(ok), 640'(1'b1));
    repeat (5) tick();
    #2 n_rst = 1'b0;
    #1;
    check("rst_mid_busy",   640'(busy),              640'(1'b0));
    check("rst_mid_digest", 640'(digest),            640'(0));
    check("rst_mid_enable", 640'(core_enable),       640'(1'b0));
    check("rst_mid_hash",   640'(core_current_hash), 640'(0));
    tick(); tick();
    n_rst = 1'b1;
    repeat (3) tick();
    check("rst_mid_no_done",  640'(done_cnt - d0), 640'(0));
    check("rst_mid_no_error", 640'(err_cnt - e0),  640'(0));
    lat = 20;
    start_pulse(hdr_b);
    wait_done(ok);
    check("rst_after_done_seen", 640'(ok), 640'(1'b1));
    check("rst_after_digest", 640'(digest), 640'(exp_digest(hdr_b)));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
